// File: rtl/wb_register_file.sv
// MIPS 32x32 general-purpose register file, fed by the writeback stage.
// Two combinational read ports with optional write-first bypass.
module wb_register_file #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int BYPASS_EN = 1
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] WriteRegister,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [ADDR_W-1:0] ReadRegister1,
  input  logic [ADDR_W-1:0] ReadRegister2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam bit BYP   = (BYPASS_EN != 0);

  logic [DATA_W-1:0] regs [DEPTH];
  logic              wr_en;
  logic              byp_en;

  assign wr_en  = RegWrite && (WriteRegister != '0);
  // a write cancelled by reset must never be forwarded
  assign byp_en = BYP && Rst_n && wr_en;

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[WriteRegister] <= WriteData;
    end
  end

  always_comb begin
    ReadData1 = regs[ReadRegister1];
    if (ReadRegister1 == '0) begin
      ReadData1 = '0;
    end else if (byp_en && (ReadRegister1 == WriteRegister)) begin
      ReadData1 = WriteData;
    end
  end

  always_comb begin
    ReadData2 = regs[ReadRegister2];
    if (ReadRegister2 == '0) begin
      ReadData2 = '0;
    end else if (byp_en && (ReadRegister2 == WriteRegister)) begin
      ReadData2 = WriteData;
    end
  end

endmodule

// File: doc/wb_register_file.md
Name: wb_register_file

Overview:
- 32-entry x 32-bit MIPS general-purpose register file.
- Consumer end of the writeback path: takes the registered RegWrite, destination index and selected writeback data, and serves two combinational read ports to ID.
- Write-first internal bypass: an ID-stage read of the register being written in the same cycle returns the new value. This removes the WB->ID hazard without extra forwarding logic.
- Register 0 is hardwired to zero.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register index width; depth = 2**ADDR_W
- BYPASS_EN, 1, 1 = write-first same-cycle bypass on read ports; 0 = read returns pre-write contents

Ports:
- Clk  input  1  system clock; all state updates on posedge
- Rst_n  input  1  synchronous active-low reset; sampled on posedge Clk
- RegWrite  input  1  write enable from the writeback stage
- WriteRegister  input  ADDR_W  destination index from the writeback stage
- WriteData  input  DATA_W  writeback data, already muxed by MemToReg
- ReadRegister1  input  ADDR_W  read port 1 index (rs)
- ReadRegister2  input  ADDR_W  read port 2 index (rt)
- ReadData1  output  DATA_W  read port 1 data, combinational
- ReadData2  output  DATA_W  read port 2 data, combinational

Behaviour:
- Storage: array regs[0..2**ADDR_W-1] of DATA_W bits.
- Reset:
  - On posedge Clk with Rst_n=0, every entry is cleared to 0 and any write that cycle is discarded.
  - Both outputs read 0 for every index after that edge.
  - Reset mid-stream (RegWrite=1 in the same cycle) loses the write.
  - Entries are not zero at time 0 before the first reset edge, except reg 0, which always reads 0.
- Write:
  - On posedge Clk with Rst_n=1, RegWrite=1 and WriteRegister!=0: regs[WriteRegister] <= WriteData.
  - Takes effect in one edge.
  - Writes to index 0 are ignored; regs[0] stays 0.
- Read: combinational, zero-cycle latency.
  - Index 0 always returns 0, regardless of bypass.
  - If BYPASS_EN=1 and Rst_n=1 and RegWrite=1 and WriteRegister!=0 and ReadRegisterN==WriteRegister, then ReadDataN = WriteData.
  - Otherwise ReadDataN = regs[ReadRegisterN].
- Bypass gating:
  - Bypass is gated by Rst_n=1, so a write cancelled by reset is never forwarded.
  - With Rst_n=0, outputs show the pre-reset array contents until the edge.
- Simultaneous events:
  - Both read ports may address the same register, or the write target, in one cycle. Each port resolves independently by the rules above.
- Width rules:
  - No sign or zero extension inside the block. Data passes through unmodified at DATA_W bits.
  - Indices are used unsigned over the full range.
- X handling:
  - RegWrite=0 makes WriteRegister and WriteData don't-care.
  - The array must not change when RegWrite=0.
- Implementation:
  - One clocked always block for reset and write.
  - Continuous/combinational logic for the reads.
  - No latches.

Test Plan:
- Reset: hold Rst_n=0 one edge with RegWrite=1, WriteRegister=5, WriteData=32'hDEAD_BEEF -> after the edge, ReadRegister1=5 gives 0 and ReadRegister2=31 gives 0.
- Basic write/read: write 32'h0000_1234 to reg 8, then 32'hFFFF_FFFF to reg 31 on consecutive edges, RegWrite=0 after -> ReadData1(8)=32'h0000_1234, ReadData2(31)=32'hFFFF_FFFF, both stable over 3 idle cycles.
- Zero register: RegWrite=1, WriteRegister=0, WriteData=32'hA5A5_A5A5 -> ReadData1(0)=0 during that cycle (no bypass) and after the edge.
- Bypass: reg 9 holds 32'h1, drive RegWrite=1, WriteRegister=9, WriteData=32'h2, ReadRegister1=ReadRegister2=9 -> both outputs 32'h2 before the edge. With BYPASS_EN=0, both show 32'h1 before the edge and 32'h2 after.
- Reset cancels bypass: reg 9=32'h1, Rst_n=0, RegWrite=1, WriteRegister=9, WriteData=32'h7 -> ReadData1=32'h1 before the edge, 0 after.
- Write disabled: RegWrite=0, WriteRegister=12, WriteData=32'hCAFE_0000, reg 12 previously 32'h55 -> reg 12 still reads 32'h55 after 2 edges.
